// File: rtl/keypad_pkg.sv
// Shared types, key map and row-decode helper for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } row_low_t;

  // Hex code per key, indexed [row][col] with row 0 at the top, col 0 at the left.
  localparam logic [0:3][0:3][3:0] KEY_MAP = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // A press is recognised only when exactly one row line is low.
  function automatic row_low_t one_low(input logic [3:0] row);
    row_low_t r;
    r = '0;
    case (row)
      4'b1110: r = '{valid: 1'b1, idx: 2'd0};
      4'b1101: r = '{valid: 1'b1, idx: 2'd1};
      4'b1011: r = '{valid: 1'b1, idx: 2'd2};
      4'b0111: r = '{valid: 1'b1, idx: 2'd3};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines; idles at all-ones.
module row_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_i,
  output logic [3:0] row_s_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= row_i;
      sync_q <= meta_q;
    end
  end

  assign row_s_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad front end: debounces a single key and emits one
// hex code with a one-cycle flag per accepted press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 50_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col_n,
  output logic [3:0] keyboard_val,
  output logic       flag
);

  localparam int unsigned SCW = $clog2(SCAN_DIV) + 1;
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [SCW-1:0] SC_LAST = SCW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]     row_s;
  row_low_t       low;

  state_e         state_q,    state_d;
  logic [1:0]     col_idx_q,  col_idx_d;
  logic [1:0]     row_lat_q,  row_lat_d;
  logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DBW-1:0] db_cnt_q,   db_cnt_d;
  logic [3:0]     col_n_q,    col_n_d;
  logic [3:0]     key_q,      key_d;
  logic           flag_q,     flag_d;

  row_sync u_row_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .row_i   (row),
    .row_s_o (row_s)
  );

  assign low = one_low(row_s);

  // Counters only advance below their terminal value, so they can never wrap.
  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    row_lat_d  = row_lat_q;
    scan_cnt_d = scan_cnt_q;
    db_cnt_d   = db_cnt_q;
    key_d      = key_q;
    flag_d     = 1'b0;
    col_n_d    = ~(4'b0001 << col_idx_q);

    case (state_q)
      SCAN: begin
        if (scan_cnt_q == SC_LAST) begin
          scan_cnt_d = '0;
          if (low.valid) begin
            row_lat_d = low.idx;
            db_cnt_d  = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + SCW'(1);
        end
      end

      DEBOUNCE: begin
        if (row_s == ~(4'b0001 << row_lat_q)) begin
          if (db_cnt_q == DB_LAST) begin
            key_d    = KEY_MAP[row_lat_q][col_idx_q];
            flag_d   = 1'b1;
            db_cnt_d = '0;
            state_d  = HELD;
          end else begin
            db_cnt_d = db_cnt_q + DBW'(1);
          end
        end else begin
          db_cnt_d  = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = SCAN;
        end
      end

      HELD: begin
        if (row_s == 4'hF) begin
          if (db_cnt_q == DB_LAST) begin
            db_cnt_d  = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = SCAN;
          end else begin
            db_cnt_d = db_cnt_q + DBW'(1);
          end
        end else begin
          db_cnt_d = '0;
        end
      end

      default: begin
        state_d    = SCAN;
        scan_cnt_d = '0;
        db_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SCAN;
      col_idx_q  <= 2'd0;
      row_lat_q  <= 2'd0;
      scan_cnt_q <= '0;
      db_cnt_q   <= '0;
      col_n_q    <= 4'b1110;
      key_q      <= 4'h0;
      flag_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      row_lat_q  <= row_lat_d;
      scan_cnt_q <= scan_cnt_d;
      db_cnt_q   <= db_cnt_d;
      col_n_q    <= col_n_d;
      key_q      <= key_d;
      flag_q     <= flag_d;
    end
  end

  assign col_n        = col_n_q;
  assign keyboard_val = key_q;
  assign flag         = flag_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad matrix model drives the rows,
// stimulus queues expected codes, a monitor checks each flag pulse.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV        = 4;
  localparam int unsigned DEBOUNCE_CYCLES = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col_n;
  logic [3:0] keyboard_val;
  logic       flag;

  logic [15:0] key_down;
  logic [3:0]  exp_q[$];
  int          n_tests;
  int          n_fail;

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .row          (row),
    .col_n        (col_n),
    .keyboard_val (keyboard_val),
    .flag         (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical matrix: a held key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && !col_n[c]) row[r] = 1'b0;
  end

  function automatic logic [3:0] key_code(input int r, input int c);
    string m;
    byte   ch;
    m  = "123A456B789CE0FD";
    ch = m[r*4+c];
    if (ch >= "0" && ch <= "9") return 4'(ch - "0");
    return 4'(ch - "A" + 10);
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic wait_col(input logic [3:0] want, input int budget);
    int n;
    n = 0;
    while (col_n !== want && n < budget) begin
      cyc(1);
      n++;
    end
    n_tests++;
    if (col_n !== want) begin
      n_fail++;
      $display("FAIL wait_col: col_n=%b, expected %b within %0d cycles", col_n, want, budget);
    end
  endtask

  // Press one key for dur cycles; long presses must yield exactly one code, short ones none.
  task automatic press(input int r, input int c, input int dur);
    if (dur >= 40) exp_q.push_back(key_code(r, c));
    key_down[r*4+c] = 1'b1;
    cyc(dur);
    key_down[r*4+c] = 1'b0;
    cyc(30);
  endtask

  // Monitor: pops one expected code per flag and checks pulse width and value hold.
  initial begin
    logic       prev_flag;
    logic [3:0] prev_val;
    logic [3:0] last_exp;
    logic [3:0] e;
    prev_flag = 1'b0;
    prev_val  = 4'h0;
    last_exp  = 4'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_exp = 4'h0;
      end else if (flag) begin
        check("flag_width", {3'b0, prev_flag}, 4'h0);
        check("val_hold", prev_val, last_exp);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_flag: keyboard_val=%h, expected no flag", keyboard_val);
        end else begin
          e = exp_q.pop_front();
          if (keyboard_val !== e) begin
            n_fail++;
            $display("FAIL key_code: got %h, expected %h", keyboard_val, e);
          end
          last_exp = e;
        end
      end
      prev_flag = flag;
      prev_val  = keyboard_val;
    end
  end

  initial begin
    logic [3:0] e;
    int r, c, dur;
    n_tests  = 0;
    n_fail   = 0;
    key_down = '0;
    rst_n    = 1'b0;

    // Reset values and free-running scan order
    cyc(3);
    check("rst_col_n", col_n, 4'b1110);
    check("rst_val", keyboard_val, 4'h0);
    check("rst_flag", {3'b0, flag}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      e = ~(4'b0001 << (((k - 1) / 4) % 4));
      check("scan_seq", col_n, e);
    end
    cyc(10);

    // Clean press of '8' (row 2, col 1)
    press(2, 1, 40);

    // Bouncing 'A' (row 0, col 3), then a stable hold
    for (int i = 0; i < 10; i++) begin
      key_down[3] = ~key_down[3];
      cyc(3);
    end
    key_down[3] = 1'b0;
    press(0, 3, 60);

    // Long hold of '*' with a short release glitch, then '#'
    exp_q.push_back(key_code(3, 0));
    key_down[12] = 1'b1;
    cyc(200);
    key_down[12] = 1'b0;
    cyc(5);
    key_down[12] = 1'b1;
    cyc(30);
    key_down[12] = 1'b0;
    cyc(30);
    press(3, 2, 40);

    // Two rows low in column 1: ignored, scanning keeps moving
    key_down[9]  = 1'b1;
    key_down[13] = 1'b1;
    cyc(40);
    wait_col(4'b1110, 40);
    wait_col(4'b1011, 40);
    key_down[9]  = 1'b0;
    key_down[13] = 1'b0;
    cyc(30);

    // Reset in the middle of debouncing '0'
    wait_col(4'b1011, 40);
    key_down[13] = 1'b1;
    wait_col(4'b1101, 40);
    cyc(8);
    rst_n = 1'b0;
    #1;
    check("mid_rst_col_n", col_n, 4'b1110);
    check("mid_rst_val", keyboard_val, 4'h0);
    check("mid_rst_flag", {3'b0, flag}, 4'h0);
    key_down[13] = 1'b0;
    cyc(3);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(60);

    // Random long presses (one code each) mixed with sub-debounce taps (no code)
    for (int i = 0; i < 14; i++) begin
      r   = int'($urandom_range(0, 3));
      c   = int'($urandom_range(0, 3));
      dur = ($urandom_range(0, 2) != 0) ? int'($urandom_range(40, 90)) : int'($urandom_range(1, 6));
      press(r, c, dur);
    end

    cyc(100);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_flags: %0d codes never flagged, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
